data_mem_ls: RTL
================

// Module: data_mem_ls
// PURPOSE
//  Parametrised RV32I data memory with full load/store-size support (LB/LH/LW/LBU/LHU, SB/SH/SW).
//  Byte-lane organised, with registered read data and a valid/ready request port.
//  Detects misaligned, out-of-range and illegal-size accesses.
//  Optionally zero-clears the array after reset. Sits between the MEM stage and the data RAM.
// PARAMETERS
//  DEPTH_WORDS  65536  number of 32-bit words; power of two, >=4
//  INIT_CLEAR   1      1: zero-fill whole array after reset; 0: skip, array contents undefined
// PORTS
//  clk         in   1   single clock, all logic on posedge
//  rst         in   1   synchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   request accepted when req_valid & req_ready
//  req_we      in   1   1 store, 0 load
//  req_funct3  in   3   RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
//  rsp_valid   out  1   one-cycle pulse, exactly one per accepted request
//  rsp_rdata   out  32  formatted load data; 0 for stores and errors
//  rsp_err     out  1   access faulted, qualified by rsp_valid
//  init_done   out  1   high once the array is usable
// BEHAVIOUR
//  Reset (rst==0 at posedge): state<=INIT (INIT_CLEAR=1) or RUN (INIT_CLEAR=0), sweep idx<=0;
//   req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
//  FSM states
//   - INIT: write 0 to word idx on all 4 lanes; idx++ each cycle; req_ready=0.
//     Leave INIT when idx==DEPTH_WORDS-1 is written, giving exactly DEPTH_WORDS cycles.
//   - RUN: req_ready=1, init_done=1. RUN is terminal until the next reset.
//  Accept and latency
//   - Request accepted at posedge with req_valid & req_ready.
//   - rsp_valid=1 in the following cycle; back-to-back requests are allowed every cycle.
//   - No response backpressure.
//  Address decode: word = addr[ADDR_W-1:2] with ADDR_W=$clog2(DEPTH_WORDS)+2; lane = addr[1:0].
//  Error, checked in this priority order:
//   - illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
//   - misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
//   - out of range: addr[31:ADDR_W] != 0.
//   - On error: no array write, rsp_err=1, rsp_rdata=0.
//  Store: byte enables SB 1<<lane, SH 2'b11<<lane, SW 4'hF.
//   - Data is lane-replicated: SB {4{wd[7:0]}}, SH {2{wd[15:0]}}.
//   - Written at the accept edge; rsp_rdata=0, rsp_err=0.
//  Load: all four lanes read at the accept edge.
//   - Select byte/half by lane, then sign-extend (B/H) or zero-extend (BU/HU); W passes through.
//   - Result is registered into rsp_rdata.
//  Store then load of the same word on the next cycle returns the new data (write-first).
//  rsp_valid/rsp_rdata/rsp_err update only on accept, else rsp_valid=0 and data holds its last value.
//  Reset mid-INIT restarts the sweep at idx 0. Reset in RUN drops any pending response;
//   array contents are kept when INIT_CLEAR=0.
//  Little-endian: lane0 = addr[1:0]==0 = bits[7:0].
// STRUCTURE
//  Package data_mem_pkg holds:
//   - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - state encoding (ST_INIT, ST_RUN)
//   - function fmt_load(funct3, lane, word32) and function store_be(funct3, lane)
//  Sub-module data_mem_lane: 8-bit x DEPTH_WORDS single-port RAM with sync write and
//   combinational read; 4 instances. The top holds the FSM, decode, error logic and response registers.
// TESTING (DEPTH_WORDS=16 unless noted)
//  1 Reset release, INIT_CLEAR=1: req_ready=0 for 16 cycles, then 1; init_done rises the same cycle;
//    LW 0x3C -> 0x00000000.
//  2 SW 0x8=0x80FF7F01; then LB 0x8->0x00000001, LB 0xB->0xFFFFFF80, LBU 0xB->0x00000080,
//    LH 0xA->0xFFFF80FF, LHU 0x8->0x00007F01.
//  3 SB 0x5=0xAB then SH 0x6=0x1234 onto zeroed word; LW 0x4 -> 0x1234AB00 (store/load back-to-back).
//  4 LH 0x1, LW 0x2, SW 0x3 -> rsp_err=1, rsp_rdata=0; later LW 0x0 shows memory unchanged.
//  5 LW 0x40 (out of range), funct3=011 load, SB with funct3=100 -> rsp_err=1 each, no write.
//  6 rst low for one cycle mid-INIT (idx=7) -> sweep restarts, ready after 16 more cycles;
//    rst low with a load in flight -> rsp_valid stays 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the RV32I data memory: funct3 codes, FSM encoding,
// and the load-format / store byte-enable helpers.
package data_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Pick the addressed byte/half from a little-endian word and extend it.
    function automatic logic [31:0] fmt_load(input logic [2:0]  funct3,
                                             input logic [1:0]  lane,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    fmt_load = {{24{b[7]}}, b};
            F3_H:    fmt_load = {{16{h[15]}}, h};
            F3_W:    fmt_load = word;
            F3_BU:   fmt_load = {24'h0, b};
            F3_HU:   fmt_load = {16'h0, h};
            default: fmt_load = 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                            input logic [1:0] lane);
        case (funct3)
            F3_B:    store_be = 4'b0001 << lane;
            F3_H:    store_be = 4'b0011 << lane;
            F3_W:    store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_lane.sv
// One byte lane of the data memory: 8-bit x DEPTH_WORDS, synchronous write,
// combinational read.
module data_mem_lane #(
    parameter int DEPTH_WORDS = 65536,
    localparam int WORD_W     = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset; clearing it is the job of the INIT sweep,
    // and a reset port here would stop the RAM from mapping onto block memory.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_ls.sv
// RV32I data memory with LB/LH/LW/LBU/LHU/SB/SH/SW support, valid/ready request
// port, one-cycle registered response and fault detection.
module data_mem_ls
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 65536,
    parameter bit INIT_CLEAR  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done
);

    localparam int WORD_W = $clog2(DEPTH_WORDS);
    localparam int ADDR_W = WORD_W + 2;

    state_t            state;
    logic [WORD_W-1:0] idx;

    logic              accept;
    logic [1:0]        lane;
    logic              illegal, misaligned, out_of_range, err;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [WORD_W-1:0] ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       rd_word;

    assign accept = req_valid & req_ready;
    assign lane   = req_addr[1:0];

    // NOTE: combinational logic uses blocking '=' with a default for every
    // output first, so no path leaves a signal unassigned and no latch forms.
    always_comb begin
        illegal = 1'b0;
        if (req_we)
            illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
        else
            illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

        misaligned = 1'b0;
        if (req_funct3 inside {F3_H, F3_HU})
            misaligned = req_addr[0];
        else if (req_funct3 == F3_W)
            misaligned = (req_addr[1:0] != 2'b00);

        out_of_range = (req_addr[31:ADDR_W] != '0);
        err          = illegal | misaligned | out_of_range;

        be = store_be(req_funct3, lane);
        case (req_funct3)
            F3_B:    wdata_rep = {4{req_wdata[7:0]}};
            F3_H:    wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    // The sweep owns the RAM port during INIT; requests cannot be accepted then.
    always_comb begin
        ram_addr  = req_addr[ADDR_W-1:2];
        ram_wdata = wdata_rep;
        ram_we    = '0;
        if (!rst) begin
            ram_we = '0;
        end else if (state == ST_INIT) begin
            ram_addr  = idx;
            ram_wdata = '0;
            ram_we    = 4'hF;
        end else if (accept && req_we && !err) begin
            ram_we = be;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        data_mem_lane #(.DEPTH_WORDS(DEPTH_WORDS)) u_lane (
            .clk   (clk),
            .we    (ram_we[i]),
            .addr  (ram_addr),
            .wdata (ram_wdata[8*i +: 8]),
            .rdata (rd_word[8*i +: 8])
        );
    end

    // NOTE: all sequential state uses non-blocking '<=' so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= INIT_CLEAR ? ST_INIT : ST_RUN;
            idx       <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_err   <= err;
                rsp_rdata <= (err || req_we) ? 32'h0 : fmt_load(req_funct3, lane, rd_word);
            end
            case (state)
                ST_INIT: begin
                    idx <= idx + 1'b1;
                    if (&idx) begin
                        state     <= ST_RUN;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    init_done <= 1'b1;
                end
            endcase
        end
    end

endmodule
